fir_mac_seq: RTL



---
 rtl/fir_mac_seq.sv | 79 +++++++
 1 files changed

// File: rtl/fir_mac_seq.sv
// fir_mac_seq: sequential one-MAC-per-cycle FIR (clk, rst, in_valid/in_ready/din in, flush, coef_we/coef_addr/coef_data, out_valid/dout out)
module fir_mac_seq #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int TAPS   = 16,
  parameter int SHIFT  = 14,
  parameter int ACC_W  = DATA_W + COEF_W + $clog2(TAPS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] din,
  input  logic                     flush,
  input  logic                     coef_we,
  input  logic [$clog2(TAPS)-1:0]  coef_addr,
  input  logic signed [COEF_W-1:0] coef_data,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] dout
);
  localparam int AW = $clog2(TAPS);
  localparam int PW = DATA_W + COEF_W;
  localparam logic signed [ACC_W-1:0] DMAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] DMIN = ~DMAX;
  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;
  state_t state, state_nxt;
  logic signed [DATA_W-1:0] hist [TAPS];
  logic signed [COEF_W-1:0] coef [TAPS];
  logic [AW-1:0] head, head_inc, rd, k;
  logic signed [PW-1:0] prod;
  logic signed [ACC_W-1:0] acc, acc_nxt, acc_sh;
  logic signed [DATA_W-1:0] dsat;
  logic accept, last;
  always_comb begin
    in_ready  = state == IDLE && !flush;
    accept    = in_ready && in_valid;
    out_valid = state == OUT;
    last      = k == AW'(TAPS - 1);
    head_inc  = head == AW'(TAPS - 1) ? '0 : head + AW'(1);
    prod      = PW'(hist[rd]) * PW'(coef[k]);
    acc_nxt   = acc + ACC_W'(prod);
    acc_sh    = acc_nxt >>> SHIFT;
    dsat      = acc_sh > DMAX ? DMAX[DATA_W-1:0] : acc_sh < DMIN ? DMIN[DATA_W-1:0] : acc_sh[DATA_W-1:0];
    state_nxt = state == IDLE ? (accept ? MAC : IDLE) : state == MAC ? (last ? OUT : MAC) : IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      head  <= '0;
      rd    <= '0;
      k     <= '0;
      acc   <= '0;
      dout  <= '0;
      for (int i = 0; i < TAPS; i++) begin
        hist[i] <= '0;
        coef[i] <= (i == 0) ? COEF_W'(1 << SHIFT) : '0;
      end
    end else begin
      state <= state_nxt;
      if (state == IDLE && flush) begin
        head <= '0;
        for (int i = 0; i < TAPS; i++) hist[i] <= '0;
      end else if (accept) begin
        hist[head_inc] <= din;
        head <= head_inc;
        rd   <= head_inc;
        k    <= '0;
        acc  <= '0;
      end
      if (state == IDLE && coef_we && 32'(coef_addr) < TAPS) coef[coef_addr] <= coef_data;
      if (state == MAC) begin
        acc <= acc_nxt;
        k   <= k + AW'(1);
        rd  <= rd == '0 ? AW'(TAPS - 1) : rd - AW'(1);
        if (last) dout <= dsat;
      end
    end
  end
endmodule
